// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: NOP word, FSM states, IF/ID register
// operations and small PC helper functions.
package instruction_fetch_pkg;

    localparam int          PC_W     = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Operation applied to a pipeline register on the next edge
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_CLEAR = 2'd1,
        IFID_LOAD  = 2'd2
    } ifid_op_e;

    // Sequential successor of a byte PC (wraps modulo 2**32)
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

    // A redirect target is only legal on a word boundary
    function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_if_id_reg.sv
// Generic pipeline register holding valid/instr/pc/pc4 with hold, clear and
// load operations. Clear turns the slot into an invalid NOP; pc fields hold.
module if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  ifid_op_e              op_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [PC_W-1:0]       pc_i,
    input  logic [PC_W-1:0]       pc4_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [PC_W-1:0]       pc_o,
    output logic [PC_W-1:0]       pc4_o
);

    localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_WORD);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [PC_W-1:0]       pc_q,    pc_d;
    logic [PC_W-1:0]       pc4_q,   pc4_d;

    // Next-state selection for the requested register operation
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        case (op_i)
            IFID_HOLD: begin
                valid_d = valid_q;
            end
            IFID_CLEAR: begin
                valid_d = 1'b0;
                instr_d = NOP_W;
            end
            IFID_LOAD: begin
                valid_d = 1'b1;
                instr_d = instr_i;
                pc_d    = pc_i;
                pc4_d   = pc4_i;
            end
            default: begin
                // Unknown operation: make the slot harmless
                valid_d = 1'b0;
                instr_d = NOP_W;
            end
        endcase
    end

    // Register storage with asynchronous reset to an empty NOP slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_W;
            pc_q    <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule : if_id_reg

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and the BOOT/RUN/FAULT controller, addresses the
// async-read instruction memory and fills the IF/ID register for decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic                  if_id_valid_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [31:0]           if_id_pc_o,
    output logic [31:0]           if_id_pc4_o,
    output logic                  fault_o
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic            fault_q, fault_d;
    ifid_op_e        ifid_op_s;
    logic [PC_W-1:0] pc_plus4_s;

    assign pc_plus4_s = pc_inc(pc_q);

    // Controller: next state, next PC and IF/ID operation by fetch priority
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        ifid_op_s = IFID_HOLD;
        case (state_q)
            ST_BOOT: begin
                // One settling edge after reset: nothing captured, PC kept
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    // Wrong-path squash; a misaligned target parks the stage
                    ifid_op_s = IFID_CLEAR;
                    if (is_misaligned(redirect_pc_i)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else if (stall_i) begin
                    if (flush_i) begin
                        ifid_op_s = IFID_CLEAR;
                    end else begin
                        ifid_op_s = IFID_HOLD;
                    end
                end else if (flush_i) begin
                    ifid_op_s = IFID_CLEAR;
                    pc_d      = pc_plus4_s;
                end else begin
                    ifid_op_s = IFID_LOAD;
                    pc_d      = pc_plus4_s;
                end
            end
            ST_FAULT: begin
                // Frozen until reset; IF/ID was already cleared on entry
                ifid_op_s = IFID_HOLD;
            end
            default: begin
                // Illegal encoding: fail safe into the fault state
                state_d   = ST_FAULT;
                fault_d   = 1'b1;
                ifid_op_s = IFID_CLEAR;
            end
        endcase
    end

    // State, PC and sticky fault registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Word address: upper PC bits are dropped, so fetch wraps silently
    assign imem_addr_o = pc_q[ADDR_WIDTH+1:2];
    assign fault_o     = fault_q;

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_i    (ifid_op_s),
        .instr_i (imem_data_i),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4_s),
        .valid_o (if_id_valid_o),
        .instr_o (if_id_instr_o),
        .pc_o    (if_id_pc_o),
        .pc4_o   (if_id_pc4_o)
    );

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/flush/redirect traffic against a behavioural fetch model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [5:0]  imem_addr_o;
    logic [31:0] imem_data_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic        fault_o;

    logic [31:0] mem [64];

    int checks   = 0;
    int failures = 0;

    // Reference model state (byte PC, IF/ID contents, mode flags)
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_boot;
    bit          m_fault;

    instruction_fetch #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .fault_o       (fault_o)
    );

    assign imem_data_i = mem[imem_addr_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_ipc   = 32'h0000_0000;
        m_instr = 32'h0000_0000;
        m_valid = 1'b0;
        m_boot  = 1'b1;
        m_fault = 1'b0;
    endtask

    // One clock edge of fetch behaviour using the inputs presented before it
    task automatic model_step();
        if (m_fault) begin
            m_fault = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (redirect_i) begin
            m_valid = 1'b0;
            m_instr = 32'h0000_0000;
            if (redirect_pc_i % 4 != 0) m_fault = 1'b1;
            else                        m_pc    = redirect_pc_i;
        end else if (stall_i) begin
            if (flush_i) begin
                m_valid = 1'b0;
                m_instr = 32'h0000_0000;
            end
        end else if (flush_i) begin
            m_valid = 1'b0;
            m_instr = 32'h0000_0000;
            m_pc    = m_pc + 32'd4;
        end else begin
            m_valid = 1'b1;
            m_instr = mem[(m_pc / 4) % 64];
            m_ipc   = m_pc;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  {26'd0, imem_addr_o},   (m_pc / 4) % 64);
        chk({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, m_valid});
        chk({tag, ".fault"}, {31'd0, fault_o},       {31'd0, m_fault});
        chk({tag, ".instr"}, if_id_instr_o,          m_instr);
        if (m_valid) begin
            chk({tag, ".pc"},  if_id_pc_o,  m_ipc);
            chk({tag, ".pc4"}, if_id_pc4_o, m_ipc + 32'd4);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, if_id_valid_o}, 32'd0);
        chk({tag, ".instr"}, if_id_instr_o,          32'd0);
        chk({tag, ".pc"},    if_id_pc_o,             32'd0);
        chk({tag, ".pc4"},   if_id_pc4_o,            32'd0);
        chk({tag, ".fault"}, {31'd0, fault_o},       32'd0);
        chk({tag, ".addr"},  {26'd0, imem_addr_o},   32'd0);
    endtask

    task automatic set_in(input bit st, input bit fl, input bit rd, input logic [31:0] tgt);
        stall_i       = st;
        flush_i       = fl;
        redirect_i    = rd;
        redirect_pc_i = tgt;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset held across two edges, outputs checked, released away from the edge
    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    int fault_age;

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'hAAAA_0001;
        mem[1] = 32'hBBBB_0002;
        mem[2] = 32'hCCCC_0003;
        mem[3] = 32'hDDDD_0004;
        model_reset();

        // Boot then sequential fetch of A,B,C,D
        do_reset();
        tick("boot");
        chk("boot_no_capture", {31'd0, if_id_valid_o}, 32'd0);
        tick("seqA");
        chk("seqA_instr", if_id_instr_o, 32'hAAAA_0001);
        chk("seqA_pc",    if_id_pc_o,    32'h0000_0000);
        tick("seqB");
        chk("seqB_instr", if_id_instr_o, 32'hBBBB_0002);
        tick("seqC");
        tick("seqD");
        chk("seqD_pc",  if_id_pc_o,  32'h0000_000C);
        chk("seqD_pc4", if_id_pc4_o, 32'h0000_0010);

        // Stall 3 cycles at pc=8 holding B
        do_reset();
        tick("boot2");
        tick("s_a");
        tick("s_b");
        set_in(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk("stall_addr",  {26'd0, imem_addr_o}, 32'd2);
            chk("stall_instr", if_id_instr_o,        32'hBBBB_0002);
        end

        // Redirect wins over stall
        set_in(1'b1, 1'b0, 1'b1, 32'h0000_0020);
        tick("redir_squash");
        chk("redir_squash_instr", if_id_instr_o, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        tick("redir_fetch");
        chk("redir_fetch_instr", if_id_instr_o, mem[8]);
        chk("redir_fetch_pc",    if_id_pc_o,    32'h0000_0020);

        // Stall together with flush, then plain flush
        set_in(1'b1, 1'b1, 1'b0, 32'd0);
        tick("stall_flush");
        set_in(1'b0, 1'b1, 1'b0, 32'd0);
        tick("flush");

        // Wrap from last word back to word 0
        set_in(1'b0, 1'b0, 1'b1, 32'h0000_00FC);
        tick("wrap_redir");
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        tick("wrap_63");
        chk("wrap_addr", {26'd0, imem_addr_o}, 32'd0);
        tick("wrap_0");
        chk("wrap_pc",    if_id_pc_o,  32'h0000_0100);
        chk("wrap_instr", if_id_instr_o, mem[0]);

        // Misaligned redirect parks in fault
        set_in(1'b0, 1'b0, 1'b1, 32'h0000_0022);
        tick("misalign");
        chk("misalign_fault", {31'd0, fault_o}, 32'd1);
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick("fault_hold");
            chk("fault_pc_frozen", {26'd0, imem_addr_o}, 32'd1);
        end

        // Asynchronous reset mid-stall while IF/ID is valid
        do_reset();
        tick("boot3");
        tick("ar_a");
        tick("ar_b");
        set_in(1'b1, 1'b0, 1'b0, 32'd0);
        tick("ar_stall");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        tick("ar_boot");
        tick("ar_restart");
        chk("ar_restart_instr", if_id_instr_o, 32'hAAAA_0001);

        // Randomized traffic against the model
        fault_age = 0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            if (m_fault) fault_age++;
            if (fault_age > 4) begin
                fault_age = 0;
                do_reset();
            end
            tgt = ($urandom_range(0, 1) == 0) ? {24'd0, 6'($urandom_range(0, 63)), 2'b00}
                                              : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 29) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 7) == 0, tgt);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instruction_fetch
